sample_framer: RTL and testbench

Packs decimated sigma-delta ADC samples into byte frames for the UART transmitter. Sits between the decimation filter, which produces one parallel sample per output period, and the `UART_Tx` instance, whose send/busy/data port it drives. A small FIFO absorbs sample bursts while the UART is busy. Each sample is sent as a sync byte followed by the sample bytes, MSB first.

---
 rtl/sdad_pkg.sv | 13 +
 rtl/sync_fifo.sv | 45 ++++
 rtl/sample_framer.sv | 125 ++++++++++++
 tb/tb_sample_framer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdad_pkg.sv
// Shared types and helpers for the sigma-delta ADC data path.
package sdad_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_DONE} frameState_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Bytes needed to carry a sample of the given width.
  function automatic int sampleBytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; level = wrPtr - rdPtr.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           popData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr, rdPtr;
  logic             doPush, doPop;

  assign level   = wrPtr - rdPtr;
  // level never exceeds DEPTH, so its top bit alone marks full
  assign full    = level[AW];
  assign empty   = (level == '0);
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + ONE;
      if (doPop)  rdPtr <= rdPtr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/sample_framer.sv
// Queues decimated samples and sends each as sync byte + sample bytes (MSB first) to UART_Tx.
// Optional trailing XOR checksum byte: define SAMPLE_FRAMER_CHECKSUM_EN.
module sample_framer
  import sdad_pkg::*;
#(
  parameter int C_SAMPLE_WIDTH    = 16,
  parameter int C_UART_DATA_WIDTH = 8,
  parameter int C_FIFO_DEPTH      = 8,
  parameter logic [C_UART_DATA_WIDTH-1:0] C_SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [C_SAMPLE_WIDTH-1:0]        sampleData,
  input  logic                             sampleValid,
  input  logic                             enable,
  input  logic                             ovfClr,
  input  logic                             txBusy,
  output logic                             txSend,
  output logic [C_UART_DATA_WIDTH-1:0]     txData,
  output logic                             overflow,
  output logic [$clog2(C_FIFO_DEPTH):0]    level
);
  localparam int NB = sampleBytes(C_SAMPLE_WIDTH);
  localparam int SW = NB * 8;
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
  localparam int LAST = NB + 1;
`else
  localparam int LAST = NB;
`endif

  frameState_t                   state, nextState;
  logic [C_SAMPLE_WIDTH-1:0]     fifoData;
  logic                          fifoFull, fifoEmpty, fifoPop, loadNext, drop;
  logic [SW-1:0]                 shiftReg;
  logic [C_UART_DATA_WIDTH-1:0]  topByte;
  logic [2:0]                    byteIdx;
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
  logic [C_UART_DATA_WIDTH-1:0]  chk;
`endif

  sync_fifo #(.WIDTH(C_SAMPLE_WIDTH), .DEPTH(C_FIFO_DEPTH)) fifo (
    .clk(clk), .rst(rst),
    .push(sampleValid), .pushData(sampleData),
    .pop(fifoPop), .popData(fifoData),
    .full(fifoFull), .empty(fifoEmpty), .level(level)
  );

  assign drop    = sampleValid && fifoFull && !fifoPop;
  assign topByte = shiftReg[SW-1 -: C_UART_DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    fifoPop   = 1'b0;
    loadNext  = 1'b0;
    txSend    = 1'b0;
    case (state)
      // Incoming strobe counts as occupancy so a lone sample starts a frame next cycle.
      IDLE:      if (enable && !txBusy && (!fifoEmpty || sampleValid)) nextState = LOAD;
      LOAD: begin
        fifoPop   = 1'b1;
        nextState = SEND;
      end
      SEND: begin
        txSend = 1'b1;
        if (txBusy) nextState = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!txBusy) begin
          if (byteIdx < 3'(LAST)) begin
            loadNext  = 1'b1;
            nextState = SEND;
          end else begin
            nextState = IDLE;
          end
        end
      end
      default:   nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txData   <= '0;
      shiftReg <= '0;
      byteIdx  <= '0;
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
      chk      <= '0;
`endif
    end else if (fifoPop) begin
      txData   <= C_SYNC_BYTE;
      shiftReg <= SW'(fifoData);
      byteIdx  <= '0;
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
      chk      <= '0;
`endif
    end else if (loadNext) begin
      byteIdx <= byteIdx + 3'd1;
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
      if (byteIdx == 3'(NB)) begin
        txData <= chk;
      end else begin
        txData   <= topByte;
        chk      <= chk ^ topByte;
        shiftReg <= shiftReg << 8;
      end
`else
      txData   <= topByte;
      shiftReg <= shiftReg << 8;
`endif
    end
  end

  // A drop wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)         overflow <= 1'b0;
    else if (drop)   overflow <= 1'b1;
    else if (ovfClr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_sample_framer.sv
// Scoreboard bench for sample_framer: 16-bit and 12-bit instances with a 10-cycle UART busy model.
module tb_sample_framer;
  import sdad_pkg::*;

`ifdef SAMPLE_FRAMER_CHECKSUM_EN
  localparam int FL = 4;
`else
  localparam int FL = 3;
`endif

  logic        clk = 0, rst = 1, enable = 1, ovfClr = 0, holdBusy = 0;
  logic [15:0] sampleData = '0;
  logic        sampleValid = 0;
  logic        txSend, overflow, txBusy;
  logic [7:0]  txData;
  logic [3:0]  level;
  int          busyCnt = 0;

  logic [11:0] sample12 = '0;
  logic        valid12 = 0;
  logic        txSend12, overflow12, txBusy12;
  logic [7:0]  txData12;
  logic [3:0]  level12;
  int          busy12Cnt = 0;

  int          nChecks = 0, nFail = 0;
  logic [7:0]  expQ[$], exp12Q[$];

  always #5 clk = ~clk;

  sample_framer dut (
    .clk(clk), .rst(rst), .sampleData(sampleData), .sampleValid(sampleValid),
    .enable(enable), .ovfClr(ovfClr), .txBusy(txBusy), .txSend(txSend),
    .txData(txData), .overflow(overflow), .level(level)
  );

  sample_framer #(.C_SAMPLE_WIDTH(12)) dut12 (
    .clk(clk), .rst(rst), .sampleData(sample12), .sampleValid(valid12),
    .enable(enable), .ovfClr(ovfClr), .txBusy(txBusy12), .txSend(txSend12),
    .txData(txData12), .overflow(overflow12), .level(level12)
  );

  // UART model: accepts a byte when send is high and idle, then stays busy for 10 cycles.
  assign txBusy   = (busyCnt != 0) || holdBusy;
  assign txBusy12 = (busy12Cnt != 0);
  always @(posedge clk) begin
    if (busyCnt != 0)             busyCnt <= busyCnt - 1;
    else if (txSend && !txBusy)   busyCnt <= 10;
    if (busy12Cnt != 0)           busy12Cnt <= busy12Cnt - 1;
    else if (txSend12)            busy12Cnt <= 10;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pushFrame16(input logic [15:0] s);
    expQ.push_back(8'hA5);
    expQ.push_back(s[15:8]);
    expQ.push_back(s[7:0]);
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
    expQ.push_back(s[15:8] ^ s[7:0]);
`endif
  endtask

  task automatic pushFrame12(input logic [11:0] s);
    exp12Q.push_back(8'hA5);
    exp12Q.push_back({4'h0, s[11:8]});
    exp12Q.push_back(s[7:0]);
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
    exp12Q.push_back({4'h0, s[11:8]} ^ s[7:0]);
`endif
  endtask

  task automatic pulse(input logic [15:0] d);
    @(negedge clk);
    sampleData  = d;
    sampleValid = 1;
    @(negedge clk);
    sampleValid = 0;
  endtask

  task automatic drain(input int maxCyc);
    int n = 0;
    while ((expQ.size() != 0 || exp12Q.size() != 0) && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    check("drain within budget", 32'(n < maxCyc), 32'd1);
    repeat (15) @(negedge clk);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (txSend && !txBusy) begin
          if (expQ.size() == 0) begin
            nChecks++; nFail++;
            $display("FAIL spurious byte: got %02h, none expected", txData);
          end else begin
            check("txData", {24'h0, txData}, {24'h0, expQ.pop_front()});
          end
        end
        if (txSend12 && !txBusy12) begin
          if (exp12Q.size() == 0) begin
            nChecks++; nFail++;
            $display("FAIL spurious byte12: got %02h, none expected", txData12);
          end else begin
            check("txData12", {24'h0, txData12}, {24'h0, exp12Q.pop_front()});
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("reset txSend", 32'(txSend), 0);
    check("reset txData", 32'(txData), 0);
    check("reset overflow", 32'(overflow), 0);
    check("reset level", 32'(level), 0);
    rst = 0;
    @(negedge clk);

    // Single sample latency and byte order
    pushFrame16(16'h1234);
    pulse(16'h1234);
    check("level at N+1", 32'(level), 1);
    check("txSend at N+1", 32'(txSend), 0);
    @(negedge clk);
    check("txSend at N+2", 32'(txSend), 1);
    check("level at N+2", 32'(level), 0);
    drain(200);
    check("idle after frame", 32'(dut.state), 32'(IDLE));

    // Burst into a full FIFO while UART busy
    holdBusy = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sampleData  = 16'hC000 + 16'(i);
      sampleValid = 1;
      if (i < 8) pushFrame16(16'hC000 + 16'(i));
    end
    @(negedge clk);
    sampleValid = 0;
    check("burst level", 32'(level), 8);
    check("burst overflow", 32'(overflow), 1);
    ovfClr = 1;
    @(negedge clk);
    ovfClr = 0;
    check("overflow cleared", 32'(overflow), 0);
    check("level after clear", 32'(level), 8);
    // Release busy; push lands in the LOAD cycle while full
    holdBusy = 0;
    @(negedge clk);
    sampleData  = 16'hBEEF;
    sampleValid = 1;
    pushFrame16(16'hBEEF);
    @(negedge clk);
    sampleValid = 0;
    check("full push+pop level", 32'(level), 8);
    check("full push+pop overflow", 32'(overflow), 0);
    drain(3000);

    // 12-bit width: zero-extended upper byte
    pushFrame12(12'hABC);
    @(negedge clk);
    sample12 = 12'hABC;
    valid12  = 1;
    @(negedge clk);
    valid12  = 0;
    drain(300);

    // enable low holds frames in the FIFO
    enable = 0;
    pushFrame16(16'h1111); pulse(16'h1111);
    pushFrame16(16'h2222); pulse(16'h2222);
    pushFrame16(16'h3333); pulse(16'h3333);
    repeat (20) @(negedge clk);
    check("disabled txSend", 32'(txSend), 0);
    check("disabled level", 32'(level), 3);
    check("disabled no bytes out", 32'(expQ.size()), 32'(3 * FL));
    enable = 1;
    drain(1000);

    // Reset during the second byte aborts the frame and flushes the FIFO
    expQ.push_back(8'hA5);
    expQ.push_back(8'h56);
    pulse(16'h5678);
    pulse(16'h9999);
    pulse(16'h7777);
    begin
      int n = 0;
      while (expQ.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("second byte reached", 32'(n < 100), 1);
    end
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid-frame rst txSend", 32'(txSend), 0);
    check("mid-frame rst level", 32'(level), 0);
    check("mid-frame rst overflow", 32'(overflow), 0);
    check("mid-frame rst state", 32'(dut.state), 32'(IDLE));
    repeat (60) @(negedge clk);
    check("post-rst txSend", 32'(txSend), 0);
    check("post-rst level", 32'(level), 0);

    check("queue empty", 32'(expQ.size()), 0);
    check("queue12 empty", 32'(exp12Q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
